ariphmetic_seq_ctrl: RTL
========================

Name: ariphmetic_seq_ctrl

Overview:
- Sequential controller and datapath that converts one PS/2 mouse movement packet (9-bit two's-complement X/Y) into a 9-bit unsigned magnitude Z = floor(sqrt((|X|>>SHIFT)^2 + (|Y|>>SHIFT)^2)).
- Sits between the PS/2 packet decoder and the display/LED consumer; ready/valid on both sides.
- Uses one shared multiplier, time-multiplexed between X and Y, and a bit-serial restoring square root.
- Replaces the fully combinational root chain, so timing closes at the system clock.

Parameters:
- SHIFT, 4, right-shift applied to each magnitude before squaring (legal 0..7).
- ROOT_W, 9, result width; radicand width is 2*ROOT_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  packet present on x_axis/y_axis.
- in_ready  out  1  controller idle, can accept a packet.
- x_axis  in  9  X movement, two's complement (bit 8 = sign).
- y_axis  in  9  Y movement, two's complement.
- x_ovf  in  1  X overflow flag from the PS/2 status byte.
- y_ovf  in  1  Y overflow flag from the PS/2 status byte.
- out_valid  out  1  z_axis holds a result.
- out_ready  in  1  consumer accepts the result.
- z_axis  out  ROOT_W  computed magnitude.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE, in_ready=1, out_valid=0, z_axis=0, busy=0; all internal registers cleared.
- Reset asserted mid-operation aborts the packet immediately; no partial result is ever presented.
- State machine:
  - IDLE: in_ready=1. A transfer occurs when in_valid&in_ready. That edge registers X/Y/ovf and moves to ABS.
  - ABS (1 cycle): mag = sign ? -v : v, computed on the 9-bit value, then saturated to 255. So -256 gives 255. Then shifted right by SHIFT into dx, dy (8-bit unsigned).
  - SQX (1 cycle): shared multiplier computes dx*dx; the 16-bit product is loaded into the radicand accumulator.
  - SQY (1 cycle): multiplier computes dy*dy; accumulator becomes the 18-bit sum (no overflow possible: max 2*255^2 < 2^17).
  - ROOT (ROOT_W cycles): restoring square root, one result bit per cycle, MSB first.
    - Each cycle: trial = (root<<1|1) compared against the current 2-bit-extended remainder.
    - If remainder >= trial, subtract trial and set the bit; otherwise the bit is 0.
    - An iteration counter runs ROOT_W-1 down to 0.
  - DONE: z_axis updated, out_valid=1. Holds until out_valid&out_ready, then IDLE on the next edge.
- Latency: out_valid rises exactly ROOT_W+4 cycles after the accept edge (13 at defaults).
- Throughput: one packet per ROOT_W+5 cycles at most.
- z_axis is stable while out_valid=1. It retains its last value after the handshake until the next DONE.
- in_ready=0 from accept until return to IDLE; in_valid is ignored while not ready.
- out_ready with out_valid=0 has no effect.
- Zero inputs produce z_axis=0 through the full sequence; there is no shortcut path, so latency is constant.

Optional Feature:
- Macro OVF_SATURATE_EN.
- Defined: in ABS, if x_ovf (y_ovf) is set, the X (Y) magnitude is forced to 255 regardless of the data value.
- Undefined: x_ovf/y_ovf are unused (tie-off, lint waiver), and the magnitude comes from the data only.

Decomposition:
- Shared package ps2_mouse_pkg holds:
  - state enum: IDLE, ABS, SQX, SQY, ROOT, DONE
  - constants PKT_W=9, MAG_W=8, default SHIFT and ROOT_W
- One natural sub-module: isqrt_serial, the bit-serial root engine.
  - Interface: start, radicand, done, root.
  - Internal iteration counter.
  - The controller FSM drives start and waits for done.

Test Plan:
- x=+64 (0x040), y=0 -> z_axis=4, out_valid exactly 13 cycles after accept.
- x=-48 (0x1D0), y=+64 (0x040) -> magnitudes 3,4 -> z_axis=5.
- x=-256 (0x100), y=-256 (0x100) -> magnitudes 255 -> dx=dy=15 -> radicand 450 -> z_axis=21.
- x=+15, y=+15 -> dx=dy=0 -> z_axis=0; latency still 13 cycles.
- Hold out_ready=0 for 20 cycles after DONE:
  - z_axis and out_valid stay stable; in_ready stays 0.
  - A second in_valid pulse is not accepted.
  - Release out_ready -> in_ready=1 on the next cycle.
- Assert rst_n=0 during ROOT:
  - All outputs return to reset values asynchronously, with no out_valid glitch.
  - After release, a new packet x=+32, y=0 gives z_axis=2.
- With OVF_SATURATE_EN: x=+1, x_ovf=1, y=0 -> z_axis=15.
- Without OVF_SATURATE_EN: the same stimulus gives z_axis=0.

Source files
------------

// File: rtl/ps2_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse magnitude datapath:
// controller state encoding, packet/magnitude widths and the saturating abs helper.
package ps2_mouse_pkg;

  localparam int PKT_W      = 9;
  localparam int MAG_W      = 8;
  localparam int DEF_SHIFT  = 4;
  localparam int DEF_ROOT_W = 9;

  typedef enum logic [2:0] {
    IDLE,
    ABS,
    SQX,
    SQY,
    ROOT,
    DONE
  } state_t;

  // Only -256 produces a 9-bit magnitude with the MSB set; clamp it to 255.
  function automatic logic [MAG_W-1:0] sat_mag(input logic [PKT_W-1:0] v);
    logic [PKT_W-1:0] m;
    m = v[PKT_W-1] ? -v : v;
    return m[PKT_W-1] ? '1 : m[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/isqrt_serial.sv
// Bit-serial restoring integer square root: one result bit per clock, MSB first.
// start loads the radicand; done pulses for one cycle once root is final.
module isqrt_serial #(
  parameter int ROOT_W = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2*ROOT_W-1:0] radicand,
  output logic                done,
  output logic [ROOT_W-1:0]   root
);

  localparam int RAD_W = 2 * ROOT_W;
  localparam int REM_W = ROOT_W + 2;
  localparam int CNT_W = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;

  logic [RAD_W-1:0]  rad_q;
  logic [REM_W-1:0]  rem_q;
  logic [REM_W-1:0]  rem_ext;
  logic [REM_W-1:0]  rem_nxt;
  logic [REM_W-1:0]  trial;
  logic [ROOT_W-1:0] root_q;
  logic [ROOT_W-1:0] root_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic              active_q;
  logic              done_q;
  logic              ge;

  // The remainder never exceeds 2*root, so ROOT_W+2 bits hold the shifted value.
  always_comb begin
    rem_ext  = (rem_q << 2) | REM_W'(rad_q[RAD_W-1 -: 2]);
    trial    = {root_q, 2'b01};
    ge       = (rem_ext >= trial);
    rem_nxt  = ge ? (rem_ext - trial) : rem_ext;
    root_nxt = {root_q[ROOT_W-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rad_q    <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rad_q    <= radicand;
        rem_q    <= '0;
        root_q   <= '0;
        cnt_q    <= CNT_W'(ROOT_W - 1);
        active_q <= 1'b1;
      end else if (active_q) begin
        rad_q  <= rad_q << 2;
        rem_q  <= rem_nxt;
        root_q <= root_nxt;
        cnt_q  <= cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          active_q <= 1'b0;
          done_q   <= 1'b1;
        end
      end
    end
  end

  assign done = done_q;
  assign root = root_q;

endmodule

// File: rtl/ariphmetic_seq_ctrl.sv
// PS/2 movement packet -> floor(sqrt(dx^2 + dy^2)) with one shared squarer and a serial root.
// Optional macro OVF_SATURATE_EN forces an axis magnitude to 255 when its overflow flag is set.
module ariphmetic_seq_ctrl
  import ps2_mouse_pkg::*;
#(
  parameter int SHIFT  = DEF_SHIFT,
  parameter int ROOT_W = DEF_ROOT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PKT_W-1:0]  x_axis,
  input  logic [PKT_W-1:0]  y_axis,
  input  logic              x_ovf,
  input  logic              y_ovf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROOT_W-1:0] z_axis,
  output logic              busy
);

  localparam int RAD_W = 2 * ROOT_W;

  state_t             state_q;
  state_t             state_n;
  logic [PKT_W-1:0]   x_q;
  logic [PKT_W-1:0]   y_q;
  logic [MAG_W-1:0]   mx;
  logic [MAG_W-1:0]   my;
  logic [MAG_W-1:0]   dx_q;
  logic [MAG_W-1:0]   dy_q;
  logic [MAG_W-1:0]   mul_a;
  logic [2*MAG_W-1:0] prod;
  logic [RAD_W-1:0]   acc_q;
  logic [RAD_W-1:0]   radicand;
  logic               root_start;
  logic               root_done;
  logic [ROOT_W-1:0]  root;
  logic [ROOT_W-1:0]  z_q;
  logic               out_valid_q;

`ifdef OVF_SATURATE_EN
  logic x_ovf_q;
  logic y_ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_ovf_q <= 1'b0;
      y_ovf_q <= 1'b0;
    end else if (state_q == IDLE && in_valid) begin
      x_ovf_q <= x_ovf;
      y_ovf_q <= y_ovf;
    end
  end

  assign mx = x_ovf_q ? '1 : sat_mag(x_q);
  assign my = y_ovf_q ? '1 : sat_mag(y_q);
`else
  logic unused_ovf;
  assign unused_ovf = x_ovf ^ y_ovf;
  assign mx = sat_mag(x_q);
  assign my = sat_mag(y_q);
`endif

  // One squarer serves both axes; the root engine is loaded with the final sum in SQY.
  assign mul_a      = (state_q == SQY) ? dy_q : dx_q;
  assign prod       = mul_a * mul_a;
  assign radicand   = acc_q + RAD_W'(prod);
  assign root_start = (state_q == SQY);

  isqrt_serial #(.ROOT_W(ROOT_W)) u_isqrt (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (root_start),
    .radicand (radicand),
    .done     (root_done),
    .root     (root)
  );

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_n = ABS;
      ABS:     state_n = SQX;
      SQX:     state_n = SQY;
      SQY:     state_n = ROOT;
      ROOT:    if (root_done) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // out_valid is a flop so a reset or state change can never glitch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      acc_q       <= '0;
      z_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      out_valid_q <= (state_n == DONE);
      unique case (state_q)
        IDLE: if (in_valid) begin
          x_q <= x_axis;
          y_q <= y_axis;
        end
        ABS: begin
          dx_q <= mx >> SHIFT;
          dy_q <= my >> SHIFT;
        end
        SQX:  acc_q <= RAD_W'(prod);
        SQY:  acc_q <= radicand;
        ROOT: if (root_done) z_q <= root;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign z_axis    = z_q;

endmodule
